// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM command controller.
// Serialises client word accesses and injects auto-refresh requests at a fixed period.
module sdram_arbiter #(
  parameter int AW          = 24,
  parameter int DW          = 16,
  parameter int RFSH_PERIOD = 780
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          aReq,
  input  logic          aWe,
  input  logic [AW-1:0] aAddr,
  input  logic [DW-1:0] aD,
  output logic [DW-1:0] aQ,
  output logic          aAck,
  input  logic          bReq,
  input  logic          bWe,
  input  logic [AW-1:0] bAddr,
  input  logic [DW-1:0] bD,
  output logic [DW-1:0] bQ,
  output logic          bAck,
  output logic          mReq,
  output logic          mRfsh,
  output logic          mWe,
  output logic [AW-1:0] mAddr,
  output logic [DW-1:0] mD,
  input  logic [DW-1:0] mQ,
  input  logic          mAck,
  output logic [1:0]    dbg_state_o,
  output logic [1:0]    dbg_rfsh_debt_o
);

  // Handshake: client req is a level held until its one-cycle ack; mReq/mRfsh
  // are levels held until the controller's one-cycle mAck, at most one at a time.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_REFRESH = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int TW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RFSH_PERIOD - 1);

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;    // 0 = A, 1 = B
  logic          last_q, last_d;
  logic          m_req_q, m_req_d;
  logic          m_rfsh_q, m_rfsh_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_d_q, m_d_d;
  logic [DW-1:0] a_q_q, a_q_d;
  logic [DW-1:0] b_q_q, b_q_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [1:0]    debt_q, debt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tc;
  logic          rfsh_done;
  logic          grant_b;

  assign tc        = (timer_q == '0);
  assign timer_d   = tc ? TIMER_LOAD : timer_q - 1'b1;
  assign rfsh_done = (state_q == S_REFRESH) && mAck;
  // On a tie the client that was not served last wins.
  assign grant_b   = bReq && (!aReq || !last_q);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    m_req_d  = m_req_q;
    m_rfsh_d = m_rfsh_q;
    m_we_d   = m_we_q;
    m_addr_d = m_addr_q;
    m_d_d    = m_d_q;
    a_q_d    = a_q_q;
    b_q_d    = b_q_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (debt_q != 2'd0) begin
          m_rfsh_d = 1'b1;
          state_d  = S_REFRESH;
        end else if (aReq || bReq) begin
          sel_d    = grant_b;
          m_we_d   = grant_b ? bWe   : aWe;
          m_addr_d = grant_b ? bAddr : aAddr;
          m_d_d    = grant_b ? bD    : aD;
          m_req_d  = 1'b1;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mAck) begin
          m_req_d = 1'b0;
          if (!m_we_q) begin
            if (sel_q) b_q_d = mQ;
            else       a_q_d = mQ;
          end
          last_d  = sel_q;
          a_ack_d = !sel_q;
          b_ack_d = sel_q;
          state_d = S_DONE;
        end
      end
      S_REFRESH: begin
        if (mAck) begin
          m_rfsh_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A terminal count and a completed refresh in the same cycle cancel out.
  always_comb begin
    debt_d = debt_q;
    if (tc && !rfsh_done) begin
      if (debt_q != 2'd3) debt_d = debt_q + 2'd1;
    end else if (rfsh_done && !tc) begin
      debt_d = debt_q - 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      m_req_q  <= 1'b0;
      m_rfsh_q <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= '0;
      m_d_q    <= '0;
      a_q_q    <= '0;
      b_q_q    <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      debt_q   <= 2'd0;
      timer_q  <= TIMER_LOAD;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      m_req_q  <= m_req_d;
      m_rfsh_q <= m_rfsh_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_d_q    <= m_d_d;
      a_q_q    <= a_q_d;
      b_q_q    <= b_q_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      debt_q   <= debt_d;
      timer_q  <= timer_d;
    end
  end

  assign mReq            = m_req_q;
  assign mRfsh           = m_rfsh_q;
  assign mWe             = m_we_q;
  assign mAddr           = m_addr_q;
  assign mD              = m_d_q;
  assign aQ              = a_q_q;
  assign bQ              = b_q_q;
  assign aAck            = a_ack_q;
  assign bAck            = b_ack_q;
  assign dbg_state_o     = state_q;
  assign dbg_rfsh_debt_o = debt_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed timing scenarios, then random client traffic
// scored against a transaction-level model with a memory-backed controller.
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int P  = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          aReq = 1'b0, aWe = 1'b0, bReq = 1'b0, bWe = 1'b0;
  logic [AW-1:0] aAddr = '0, bAddr = '0;
  logic [DW-1:0] aD = '0, bD = '0;
  logic [DW-1:0] aQ, bQ;
  logic          aAck, bAck;
  logic          mReq, mRfsh, mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mD;
  logic [DW-1:0] mQ = '0;
  logic          mAck = 1'b0;
  logic [1:0]    dbg_state, dbg_debt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sdram_arbiter #(.AW(AW), .DW(DW), .RFSH_PERIOD(P)) dut (
    .clock(clock), .reset(reset),
    .aReq(aReq), .aWe(aWe), .aAddr(aAddr), .aD(aD), .aQ(aQ), .aAck(aAck),
    .bReq(bReq), .bWe(bWe), .bAddr(bAddr), .bD(bD), .bQ(bQ), .bAck(bAck),
    .mReq(mReq), .mRfsh(mRfsh), .mWe(mWe), .mAddr(mAddr), .mD(mD),
    .mQ(mQ), .mAck(mAck),
    .dbg_state_o(dbg_state), .dbg_rfsh_debt_o(dbg_debt)
  );

  // Controller model: acks any request after ctl_lat cycles, backed by a word memory.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int ctl_lat = 0;
  int ctl_cnt = 0;
  bit ctl_stall = 1'b0;
  bit ctl_rand = 1'b0;

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      mAck = 1'b0;
      ctl_cnt = 0;
    end else if (mAck) begin
      mAck = 1'b0;
    end else if ((mReq || mRfsh) && !ctl_stall) begin
      if (ctl_cnt >= ctl_lat) begin
        mAck = 1'b1;
        ctl_cnt = 0;
        mQ = DW'($urandom);
        if (mReq && mWe) mem[mAddr] = mD;
        else if (mReq) mQ = mem.exists(mAddr) ? mem[mAddr] : '0;
        if (ctl_rand) ctl_lat = $urandom_range(0, 6);
      end else begin
        ctl_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    aReq = 1'b0; bReq = 1'b0; aWe = 1'b0; bWe = 1'b0;
    aAddr = '0; bAddr = '0; aD = '0; bD = '0;
    ctl_stall = 1'b0; ctl_rand = 1'b0; ctl_lat = 0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Scoreboard state for the random phase
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] a_exp_q[$];
  logic [DW-1:0] b_exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  initial begin
    int n_a, n_b, rises, last_rise, mack_i, phase, maxd, rfsh_done, n;
    bit prev_req, prev_rfsh, wrap, win, last_win, done;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] a_last, b_last, v, e;

    // Reset values
    do_reset();
    chk("rst_mreq", mReq, 0);
    chk("rst_mrfsh", mRfsh, 0);
    chk("rst_mwe", mWe, 0);
    chk("rst_maddr", mAddr, 0);
    chk("rst_md", mD, 0);
    chk("rst_aq", aQ, 0);
    chk("rst_bq", bQ, 0);
    chk("rst_aack", aAck, 0);
    chk("rst_back", bAck, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_debt", dbg_debt, 0);

    // A read returning 0xBEEF after 5 cycles
    mem[24'h000123] = 16'hBEEF;
    ctl_lat = 5;
    aReq = 1'b1; aWe = 1'b0; aAddr = 24'h000123;
    cyc();
    chk("rd_mreq_latency", mReq, 1);
    chk("rd_maddr", mAddr, 24'h000123);
    chk("rd_mwe", mWe, 0);
    n_a = 0; n_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (aAck) begin n_a++; aReq = 1'b0; end
      if (bAck) n_b++;
      cyc();
    end
    chk("rd_aack_count", n_a, 1);
    chk("rd_back_count", n_b, 0);
    chk("rd_aq", aQ, 16'hBEEF);

    // Both clients held from reset: grants alternate A,B,A,B
    do_reset();
    ctl_lat = 2;
    aAddr = 24'h000A0A; bAddr = 24'h000B0B;
    aReq = 1'b1; bReq = 1'b1;
    exp_addr_q = {24'h000A0A, 24'h000B0B, 24'h000A0A, 24'h000B0B};
    prev_req = 1'b0;
    for (int i = 0; i < 200 && exp_addr_q.size() != 0; i++) begin
      cyc();
      chk("rr_excl", mReq && mRfsh, 0);
      if (mReq && !prev_req) chk("rr_grant_addr", mAddr, exp_addr_q.pop_front());
      prev_req = mReq;
    end
    chk("rr_all_grants", exp_addr_q.size(), 0);

    // B write: fields held, bQ untouched, bAck one cycle after mAck
    do_reset();
    ctl_lat = 4;
    bReq = 1'b1; bWe = 1'b1; bAddr = 24'h00FFFF; bD = 16'h5A5A;
    n_a = 0; n_b = 0; mack_i = -1; prev_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (mReq) begin
        chk("wr_mwe", mWe, 1);
        chk("wr_md", mD, 16'h5A5A);
      end
      if (mAck && prev_req) mack_i = i;
      if (bAck) begin
        n_b++;
        chk("wr_back_after_mack", i, mack_i);
        bReq = 1'b0;
      end
      if (aAck) n_a++;
      prev_req = mReq;
    end
    chk("wr_back_count", n_b, 1);
    chk("wr_aack_count", n_a, 0);
    chk("wr_bq_unchanged", bQ, 0);
    chk("wr_mem", mem[24'h00FFFF], 16'h5A5A);

    // Refresh cadence with no clients
    do_reset();
    ctl_lat = 0;
    rises = 0; last_rise = -1; prev_rfsh = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      chk("rf_excl", mReq && mRfsh, 0);
      if (mRfsh && !prev_rfsh) begin
        if (last_rise >= 0) chk("rf_period", i - last_rise, P);
        last_rise = i;
        rises++;
      end
      prev_rfsh = mRfsh;
    end
    chk("rf_count", rises, 4);

    // 40-cycle access builds debt 2, then exactly two refreshes before next grant
    do_reset();
    ctl_lat = 39;
    aReq = 1'b1; aWe = 1'b0; aAddr = 24'h000040;
    phase = 0; rises = 0; done = 1'b0; prev_rfsh = 1'b0; prev_req = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      case (phase)
        0: if (aAck) begin
          chk("debt_after_long_access", dbg_debt, 2);
          ctl_lat = 0;
          aReq = 1'b0;
          phase = 1;
        end
        1: begin
          aReq = 1'b1; aAddr = 24'h000041;
          phase = 2;
        end
        default: begin
          if (mRfsh && !prev_rfsh) rises++;
          if (mReq && !prev_req) begin
            chk("debt_refreshes_before_grant", rises, 2);
            chk("debt_next_grant_addr", mAddr, 24'h000041);
            done = 1'b1;
          end
        end
      endcase
      prev_rfsh = mRfsh;
      prev_req = mReq;
    end
    chk("debt_sequence_completed", done, 1);

    // Reset mid-access after A was served last: outputs drop, first tie goes to A
    do_reset();
    ctl_lat = 2;
    aReq = 1'b1; aWe = 1'b0; aAddr = 24'h000055;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (aAck) aReq = 1'b0;
    end
    ctl_lat = 20;
    aReq = 1'b1;
    cyc(); cyc(); cyc();
    chk("mid_rst_mreq_before", mReq, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_mreq", mReq, 0);
    chk("mid_rst_aack", aAck, 0);
    chk("mid_rst_back", bAck, 0);
    aReq = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    aAddr = 24'h0000AA; bAddr = 24'h0000BB; bWe = 1'b0;
    aReq = 1'b1; bReq = 1'b1;
    cyc();
    chk("mid_rst_tie_mreq", mReq, 1);
    chk("mid_rst_tie_to_a", mAddr, 24'h0000AA);

    // Controller stall: debt saturates at 3 and never wraps
    do_reset();
    ctl_stall = 1'b1;
    aReq = 1'b1; aAddr = 24'h000077;
    maxd = 0; wrap = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (int'(dbg_debt) < maxd) wrap = 1'b1;
      if (int'(dbg_debt) > maxd) maxd = int'(dbg_debt);
    end
    chk("stall_debt_saturated", dbg_debt, 3);
    chk("stall_no_wrap", wrap, 0);
    chk("stall_mreq_held", mReq, 1);

    // Random traffic against the transaction model
    do_reset();
    ctl_lat = 3; ctl_rand = 1'b1;
    ref_mem.delete();
    a_exp_q.delete(); b_exp_q.delete();
    a_last = '0; b_last = '0; last_win = 1'b1;
    prev_req = 1'b0; prev_rfsh = 1'b0; rfsh_done = 0; g_addr = '0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      n++;
      chk("r_excl", mReq && mRfsh, 0);
      if (mAck && prev_rfsh) rfsh_done++;
      chk("r_a_ack", aAck, mAck && prev_req && !last_win);
      chk("r_b_ack", bAck, mAck && prev_req && last_win);
      if (aAck) begin
        if (a_exp_q.size() != 0) begin
          e = a_exp_q.pop_front();
          chk("r_a_q", aQ, e);
        end
        aReq = 1'b0;
      end
      if (bAck) begin
        if (b_exp_q.size() != 0) begin
          e = b_exp_q.pop_front();
          chk("r_b_q", bQ, e);
        end
        bReq = 1'b0;
      end
      if (mReq && prev_req) chk("r_addr_stable", mAddr, g_addr);
      if (mReq && !prev_req) begin
        chk("r_grant_has_req", aReq || bReq, 1);
        if (aReq || bReq) begin
          win = (aReq && bReq) ? !last_win : bReq;
          g_addr = win ? bAddr : aAddr;
          chk("r_grant_addr", mAddr, g_addr);
          chk("r_grant_we", mWe, win ? bWe : aWe);
          if (win ? bWe : aWe) begin
            chk("r_grant_d", mD, win ? bD : aD);
            ref_mem[g_addr] = win ? bD : aD;
            v = win ? b_last : a_last;
          end else begin
            v = ref_mem.exists(g_addr) ? ref_mem[g_addr] : '0;
          end
          if (win) begin b_exp_q.push_back(v); b_last = v; end
          else     begin a_exp_q.push_back(v); a_last = v; end
          last_win = win;
        end
      end
      prev_req = mReq;
      prev_rfsh = mRfsh;
      if (!aReq && $urandom_range(0, 2) == 0) begin
        aReq = 1'b1; aWe = 1'($urandom_range(0, 1));
        aAddr = AW'($urandom_range(0, 15)); aD = DW'($urandom);
      end
      if (!bReq && $urandom_range(0, 2) == 0) begin
        bReq = 1'b1; bWe = 1'($urandom_range(0, 1));
        bAddr = AW'($urandom_range(0, 15)); bD = DW'($urandom);
      end
    end
    chk("r_rfsh_not_ahead", (n / P) >= rfsh_done, 1);
    chk("r_rfsh_lag_bounded", (n / P) - rfsh_done <= 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
